// File: rtl/vpu_pkg.sv
// Shared vector-unit constants and types: register-file geometry and the
// write-back payload carried from the arbiter to the register-file write port.
package vpu_pkg;

  localparam int unsigned VREGS  = 8;
  localparam int unsigned VLEN   = 8;
  localparam int unsigned EWIDTH = 32;
  localparam int unsigned RW     = $clog2(VREGS);
  localparam int unsigned DW     = EWIDTH * VLEN;

  typedef logic [RW-1:0] vreg_idx_t;
  typedef logic [DW-1:0] vreg_data_t;

  typedef struct packed {
    vreg_idx_t  rd;
    vreg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (mod N);
// ptr moves to one past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  input  logic         advance
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // Priority scan starting at ptr
  always_comb begin
    gnt   = '0;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[wrap_idx(ptr, k)]) begin
        gnt[wrap_idx(ptr, k)] = 1'b1;
        win                   = wrap_idx(ptr, k);
        found                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (32'(win) == N - 1) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/vreg_wb_scheduler.sv
// Write-back scheduler for the single vector register-file write port, with a
// per-register busy scoreboard used by issue to stall RAW/WAW hazards.
module vreg_wb_scheduler
  import vpu_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*RW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic [RW-1:0]        issue_rd,
  output logic                 issue_ready,
  output logic [VREGS-1:0]     busy,
  output logic                 rf_we,
  output logic [RW-1:0]        rf_rd,
  output logic [DW-1:0]        rf_data,
  output logic                 wb_err
);

  logic [NREQ-1:0] gnt;
  logic            transfer;
  logic            issue_fire;
  wb_req_t         sel;
  wb_req_t         wb_q;
  logic [VREGS-1:0] busy_next;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .gnt     (gnt),
    .advance (transfer)
  );

  // The write port never back-pressures, so any grant is a transfer
  assign req_ready = gnt;
  assign transfer  = |(req_valid & gnt);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel.rd   = req_rd[i*RW +: RW];
        sel.data = req_data[i*DW +: DW];
      end
    end
  end

  // Registered write port; index/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      wb_q  <= '0;
    end else begin
      rf_we <= transfer;
      if (transfer) wb_q <= sel;
    end
  end

  assign rf_rd   = wb_q.rd;
  assign rf_data = wb_q.data;

  // No bypass: a register being cleared this cycle still reads as busy
  assign issue_ready = !busy[issue_rd];
  assign issue_fire  = issue_valid && issue_ready;

  // Clear on commit first so a same-edge new producer wins
  always_comb begin
    busy_next = busy;
    if (rf_we)      busy_next[rf_rd]    = 1'b0;
    if (issue_fire) busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (rf_we && !busy[rf_rd]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vreg_wb_scheduler.sv
// Self-checking bench for vreg_wb_scheduler: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_vreg_wb_scheduler;

  localparam int NREQ  = 2;
  localparam int RW    = 3;
  localparam int VREGS = 8;
  localparam int DW    = 256;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*RW-1:0]   req_rd;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 issue_valid;
  logic [RW-1:0]        issue_rd;
  logic                 issue_ready;
  logic [VREGS-1:0]     busy;
  logic                 rf_we;
  logic [RW-1:0]        rf_rd;
  logic [DW-1:0]        rf_data;
  logic                 wb_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] pat_a5;
  logic [DW-1:0] pat_5a;

  // Reference model state
  int               m_ptr;
  logic [VREGS-1:0] m_busy;
  logic             m_we;
  logic [RW-1:0]    m_rd;
  logic [DW-1:0]    m_data;
  logic             m_err;

  vreg_wb_scheduler #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .busy        (busy),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_err  = 1'b0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    logic [VREGS-1:0] nb;
    nb = m_busy;
    if (m_we && !m_busy[m_rd]) m_err = 1'b1;
    if (m_we) nb[m_rd] = 1'b0;
    if (issue_valid && !m_busy[issue_rd]) nb[issue_rd] = 1'b1;
    m_busy = nb;
    if (g >= 0) begin
      m_rd   = req_rd[g*RW +: RW];
      m_data = req_data[g*DW +: DW];
      m_ptr  = (g + 1) % NREQ;
    end
    m_we = (g >= 0);
  endtask

  task automatic test_reset();
    idle();
    issue_valid = 1'b1;
    issue_rd    = 3'd2;
    req_valid   = 2'b01;
    req_rd[2:0] = 3'd2;
    req_data[DW-1:0] = pat_a5;
    tick();
    idle();
    issue_rd = 3'd2;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
    checks++; if (rf_rd !== 3'd0) begin errors++; $display("FAIL reset_rf_rd: got %0d expected 0", rf_rd); end
    checks++; if (rf_data !== '0) begin errors++; $display("FAIL reset_rf_data: got %h expected 0", rf_data); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h expected 00", busy); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err: got %b expected 0", wb_err); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_req_ready: got %b expected 01", req_ready); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 3'd3;
    #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_issue_ready: got %b expected 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    checks++; if (busy !== 8'h08) begin errors++; $display("FAIL single_busy_set: got %h expected 08", busy); end
    req_valid   = 2'b01;
    req_rd[2:0] = 3'd3;
    req_data[DW-1:0] = pat_a5;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_rf_we: got %b expected 1", rf_we); end
    checks++; if (rf_rd !== 3'd3) begin errors++; $display("FAIL single_rf_rd: got %0d expected 3", rf_rd); end
    checks++; if (rf_data !== pat_a5) begin errors++; $display("FAIL single_rf_data: got %h expected %h", rf_data, pat_a5); end
    checks++; if (busy !== 8'h08) begin errors++; $display("FAIL single_busy_hold: got %h expected 08", busy); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_rf_we_drop: got %b expected 0", rf_we); end
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL single_busy_clear: got %h expected 00", busy); end
    checks++; if (rf_rd !== 3'd3) begin errors++; $display("FAIL single_rf_rd_hold: got %0d expected 3", rf_rd); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL single_wb_err: got %b expected 0", wb_err); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_gnt;
    logic [RW-1:0]   exp_rd;
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 3'd1;
    tick();
    issue_rd = 3'd2;
    tick();
    issue_valid = 1'b0;
    checks++; if (busy !== 8'h06) begin errors++; $display("FAIL cont_busy: got %h expected 06", busy); end
    req_valid = 2'b11;
    req_rd    = {3'd2, 3'd1};
    req_data  = {pat_5a, pat_a5};
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rd  = (k % 2 == 0) ? 3'd1 : 3'd2;
      #1;
      checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL cont_gnt%0d: got %b expected %b", k, req_ready, exp_gnt); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_rd !== exp_rd) begin errors++; $display("FAIL cont_wb%0d: got we=%b rd=%0d expected we=1 rd=%0d", k, rf_we, rf_rd, exp_rd); end
    end
    idle();
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b expected 0", rf_we); end
  endtask

  task automatic test_hazard();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 3'd5;
    tick();
    #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall: got %b expected 0", issue_ready); end
    tick();
    checks++; if (busy !== 8'h20) begin errors++; $display("FAIL hazard_busy_hold: got %h expected 20", busy); end
    req_valid   = 2'b01;
    req_rd[2:0] = 3'd5;
    req_data[DW-1:0] = pat_5a;
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (rf_we !== 1'b1 || issue_ready !== 1'b0) begin errors++; $display("FAIL hazard_no_bypass: got we=%b ready=%b expected we=1 ready=0", rf_we, issue_ready); end
    tick();
    checks++; if (busy !== 8'h00) begin errors++; $display("FAIL hazard_busy_clear: got %h expected 00", busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %b expected 1", issue_ready); end
    idle();
  endtask

  task automatic test_same_edge();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 3'd4;
    tick();
    issue_valid = 1'b0;
    req_valid   = 2'b10;
    req_rd[5:3] = 3'd4;
    req_data[2*DW-1:DW] = pat_a5;
    tick();
    req_valid   = 2'b00;
    issue_valid = 1'b1;
    issue_rd    = 3'd6;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 3'd4) begin errors++; $display("FAIL same_wb: got we=%b rd=%0d expected we=1 rd=4", rf_we, rf_rd); end
    tick();
    idle();
    checks++; if (busy !== 8'h40) begin errors++; $display("FAIL same_busy: got %h expected 40", busy); end
  endtask

  task automatic test_error();
    do_reset();
    req_valid   = 2'b01;
    req_rd[2:0] = 3'd7;
    req_data[DW-1:0] = pat_5a;
    tick();
    req_valid = 2'b00;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 3'd7 || rf_data !== pat_5a) begin errors++; $display("FAIL err_write: got we=%b rd=%0d expected we=1 rd=7", rf_we, rf_rd); end
    tick();
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", wb_err); end
    repeat (5) tick();
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", wb_err); end
    do_reset();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b expected 0", wb_err); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] hold;
    logic [NREQ-1:0] exp_rdy;
    int g;
    do_reset();
    model_reset();
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hold[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_rd[i*RW +: RW] = RW'($urandom_range(0, VREGS - 1));
          for (int w = 0; w < DW / 32; w++) req_data[i*DW + w*32 +: 32] = $urandom();
        end
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = RW'($urandom_range(0, VREGS - 1));
      #1;
      g = model_grant();
      exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_req_ready c%0d: got %b expected %b", c, req_ready, exp_rdy); end
      checks++; if (issue_ready !== !m_busy[issue_rd]) begin errors++; $display("FAIL rnd_issue_ready c%0d: got %b expected %b", c, issue_ready, !m_busy[issue_rd]); end
      hold = req_valid & ~exp_rdy;
      @(posedge clk);
      model_edge(g);
      #1;
      checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rnd_rf_we c%0d: got %b expected %b", c, rf_we, m_we); end
      checks++; if (rf_rd !== m_rd) begin errors++; $display("FAIL rnd_rf_rd c%0d: got %0d expected %0d", c, rf_rd, m_rd); end
      checks++; if (rf_data !== m_data) begin errors++; $display("FAIL rnd_rf_data c%0d: got %h expected %h", c, rf_data, m_data); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %h expected %h", c, busy, m_busy); end
      checks++; if (wb_err !== m_err) begin errors++; $display("FAIL rnd_wb_err c%0d: got %b expected %b", c, wb_err, m_err); end
    end
    idle();
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};
    idle();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_hazard();
    test_same_edge();
    test_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
